// File: rtl/tlb_lookup_pkg.sv
// Shared types, w_entry layout and INVTLB op encodings for the TLB lookup block.
package tlb_lookup_pkg;

    localparam int unsigned TLB_ENTRIES_DEF = 16;

    // w_entry is 89 bits wide. The defined fields fill bits [83:0], with the
    // listed field order running MSB to LSB. Bits [88:84] are reserved and ignored.
    localparam int unsigned W_ENTRY_W  = 89;
    localparam int unsigned ENTRY_BITS = 84;
    localparam int unsigned OFF_V1   = 0;
    localparam int unsigned OFF_D1   = 1;
    localparam int unsigned OFF_MAT1 = 2;
    localparam int unsigned OFF_PLV1 = 4;
    localparam int unsigned OFF_PPN1 = 6;
    localparam int unsigned OFF_V0   = 26;
    localparam int unsigned OFF_D0   = 27;
    localparam int unsigned OFF_MAT0 = 28;
    localparam int unsigned OFF_PLV0 = 30;
    localparam int unsigned OFF_PPN0 = 32;
    localparam int unsigned OFF_ASID = 52;
    localparam int unsigned OFF_G    = 62;
    localparam int unsigned OFF_PS4M = 63;
    localparam int unsigned OFF_VPPN = 64;
    localparam int unsigned OFF_E    = 83;

    typedef struct packed {
        logic        e;
        logic [18:0] vppn;
        logic        ps4m;
        logic        g;
        logic [9:0]  asid;
        logic [19:0] ppn0;
        logic [1:0]  plv0;
        logic [1:0]  mat0;
        logic        d0;
        logic        v0;
        logic [19:0] ppn1;
        logic [1:0]  plv1;
        logic [1:0]  mat1;
        logic        d1;
        logic        v1;
    } tlb_entry_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } inv_state_e;

    localparam logic [4:0] INV_ALL      = 5'd0;
    localparam logic [4:0] INV_ALL_ALT  = 5'd1;
    localparam logic [4:0] INV_GLOBAL   = 5'd2;
    localparam logic [4:0] INV_PRIVATE  = 5'd3;
    localparam logic [4:0] INV_ASID     = 5'd4;
    localparam logic [4:0] INV_ASID_VA  = 5'd5;
    localparam logic [4:0] INV_GASID_VA = 5'd6;
    localparam logic [4:0] INV_OP_MAX   = 5'd6;

    // VA compare honouring page size; shared by lookup and the INVTLB sweep.
    function automatic logic va_match(input tlb_entry_t ent, input logic [31:0] va);
        return ent.ps4m ? (ent.vppn[18:9] == va[31:22]) : (ent.vppn == va[31:13]);
    endfunction

    // INVTLB clear condition for one entry.
    function automatic logic inv_clear(input logic [4:0] op, input tlb_entry_t ent,
                                       input logic [9:0] asid, input logic [31:0] va);
        logic am;
        logic vm;
        am = (ent.asid == asid);
        vm = va_match(ent, va);
        case (op)
            INV_ALL, INV_ALL_ALT: return 1'b1;
            INV_GLOBAL:           return ent.g;
            INV_PRIVATE:          return ~ent.g;
            INV_ASID:             return ~ent.g & am;
            INV_ASID_VA:          return ~ent.g & am & vm;
            INV_GASID_VA:         return (ent.g | am) & vm;
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/tlb_lookup_match.sv
// Combinational TLB compare, lowest-index priority encode and odd/even page select.
module tlb_match
    import tlb_lookup_pkg::*;
#(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
    input  tlb_entry_t [ENTRIES-1:0] entries,
    input  logic [31:0]              vaddr,
    input  logic [9:0]               asid,
    output logic                     hit,
    output logic [IDX_W-1:0]         idx,
    output logic                     v,
    output logic                     d,
    output logic [1:0]               plv,
    output logic [1:0]               mat,
    output logic [31:0]              paddr
);

    tlb_entry_t  sel;
    logic        odd;
    logic [19:0] ppn;

    // Find the lowest matching entry.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (!hit && entries[i].e && (entries[i].g || entries[i].asid == asid) &&
                va_match(entries[i], vaddr)) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

    // Pick the odd/even page of the winner and form the physical address.
    always_comb begin
        sel   = entries[idx];
        odd   = sel.ps4m ? vaddr[21] : vaddr[12];
        ppn   = odd ? sel.ppn1 : sel.ppn0;
        v     = 1'b0;
        d     = 1'b0;
        plv   = '0;
        mat   = '0;
        paddr = '0;
        if (hit) begin
            v     = odd ? sel.v1 : sel.v0;
            d     = odd ? sel.d1 : sel.d0;
            plv   = odd ? sel.plv1 : sel.plv0;
            mat   = odd ? sel.mat1 : sel.mat0;
            paddr = sel.ps4m ? {ppn[19:9], vaddr[20:0]} : {ppn, vaddr[11:0]};
        end
    end

endmodule

// File: rtl/tlb_lookup.sv
// Dual-port TLB array: registered lookups, entry write port and INVTLB sweep engine.
module tlb_lookup
    import tlb_lookup_pkg::*;
#(
    parameter int unsigned TLB_ENTRIES = TLB_ENTRIES_DEF,
    parameter int unsigned IDX_W       = $clog2(TLB_ENTRIES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 lk_valid0,
    input  logic                 lk_valid1,
    input  logic [31:0]          lk_vaddr0,
    input  logic [31:0]          lk_vaddr1,
    input  logic [9:0]           lk_asid,
    output logic                 hit0,
    output logic                 hit1,
    output logic                 tlb_v0,
    output logic                 tlb_v1,
    output logic                 tlb_d0,
    output logic                 tlb_d1,
    output logic [1:0]           tlb_plv0,
    output logic [1:0]           tlb_plv1,
    output logic [1:0]           tlb_mat0,
    output logic [1:0]           tlb_mat1,
    output logic [31:0]          paddr0,
    output logic [31:0]          paddr1,
    output logic [IDX_W-1:0]     hit_idx1,
    output logic                 out_valid0,
    output logic                 out_valid1,
    input  logic                 we,
    input  logic [IDX_W-1:0]     w_idx,
    input  logic [W_ENTRY_W-1:0] w_entry,
    input  logic                 inv_req,
    input  logic [4:0]           inv_op,
    input  logic [9:0]           inv_asid,
    input  logic [31:0]          inv_va,
    output logic                 inv_busy,
    output logic                 inv_done,
    output logic                 inv_ine
);

    tlb_entry_t [TLB_ENTRIES-1:0] arr;
    inv_state_e                   state, state_nxt;
    logic [IDX_W-1:0]             cnt;
    logic [4:0]                   op_q;
    logic [9:0]                   asid_q;
    logic [31:0]                  va_q;
    logic                         start;
    logic                         ine_nxt;
    logic                         unused_rsvd;
    logic [IDX_W-1:0]             unused_idx0;

    logic                         m0_hit, m1_hit, m0_v, m1_v, m0_d, m1_d;
    logic [1:0]                   m0_plv, m1_plv, m0_mat, m1_mat;
    logic [31:0]                  m0_paddr, m1_paddr;
    logic [IDX_W-1:0]             m1_idx;

    // Reserved upper w_entry bits carry no state.
    assign unused_rsvd = ^w_entry[W_ENTRY_W-1:ENTRY_BITS];

    tlb_match #(.ENTRIES(TLB_ENTRIES), .IDX_W(IDX_W)) u_match0 (
        .entries(arr), .vaddr(lk_vaddr0), .asid(lk_asid),
        .hit(m0_hit), .idx(unused_idx0), .v(m0_v), .d(m0_d),
        .plv(m0_plv), .mat(m0_mat), .paddr(m0_paddr)
    );

    tlb_match #(.ENTRIES(TLB_ENTRIES), .IDX_W(IDX_W)) u_match1 (
        .entries(arr), .vaddr(lk_vaddr1), .asid(lk_asid),
        .hit(m1_hit), .idx(m1_idx), .v(m1_v), .d(m1_d),
        .plv(m1_plv), .mat(m1_mat), .paddr(m1_paddr)
    );

    // Sweep FSM next state, start/illegal-op decode and status outputs.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        ine_nxt   = 1'b0;
        inv_busy  = (state == ST_SWEEP);
        inv_done  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (inv_req) begin
                    if (inv_op <= INV_OP_MAX) begin
                        start     = 1'b1;
                        state_nxt = ST_SWEEP;
                    end else begin
                        ine_nxt = 1'b1;
                    end
                end
            end
            ST_SWEEP: begin
                if (cnt == IDX_W'(TLB_ENTRIES - 1)) begin
                    inv_done  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Latch INVTLB operands at start and step the sweep counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            op_q   <= '0;
            asid_q <= '0;
            va_q   <= '0;
        end else if (start) begin
            cnt    <= '0;
            op_q   <= inv_op;
            asid_q <= inv_asid;
            va_q   <= inv_va;
        end else if (inv_busy) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Entry array: write port when idle, one entry cleared per sweep cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            arr <= '0;
        end else begin
            if (we && !inv_busy)
                arr[w_idx] <= tlb_entry_t'(w_entry[ENTRY_BITS-1:0]);
            if (inv_busy && inv_clear(op_q, arr[cnt], asid_q, va_q))
                arr[cnt].e <= 1'b0;
        end
    end

    // Lookup output stage, held while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            inv_ine    <= 1'b0;
            hit0       <= 1'b0;
            hit1       <= 1'b0;
            tlb_v0     <= 1'b0;
            tlb_v1     <= 1'b0;
            tlb_d0     <= 1'b0;
            tlb_d1     <= 1'b0;
            tlb_plv0   <= '0;
            tlb_plv1   <= '0;
            tlb_mat0   <= '0;
            tlb_mat1   <= '0;
            paddr0     <= '0;
            paddr1     <= '0;
            hit_idx1   <= '0;
            out_valid0 <= 1'b0;
            out_valid1 <= 1'b0;
        end else begin
            inv_ine <= ine_nxt;
            if (!stall) begin
                hit0       <= m0_hit;
                hit1       <= m1_hit;
                tlb_v0     <= m0_v;
                tlb_v1     <= m1_v;
                tlb_d0     <= m0_d;
                tlb_d1     <= m1_d;
                tlb_plv0   <= m0_plv;
                tlb_plv1   <= m1_plv;
                tlb_mat0   <= m0_mat;
                tlb_mat1   <= m1_mat;
                paddr0     <= m0_paddr;
                paddr1     <= m1_paddr;
                hit_idx1   <= m1_idx;
                out_valid0 <= lk_valid0 & ~inv_busy;
                out_valid1 <= lk_valid1 & ~inv_busy;
            end
        end
    end

endmodule
